elevator_core_n: RTL
====================

Name: elevator_core_n

Overview:
- Parametrised elevator scheduling core. Successor to the fixed 8-floor controller/simulator pair.
- Latches inside, up and down calls for NUM_FLOORS floors and runs a SCAN policy: keep the current direction while requests remain ahead, otherwise reverse.
- Models travel time and door dwell with tick-driven counters. Exports floor, direction and door state to the display adapter.
- Sits between input_manager and display_adapter. All timing advances on the `tick` strobe from clock_divider.

Parameters:
- NUM_FLOORS, 8, number of floors (2..16), numbered 0..NUM_FLOORS-1
- FLOOR_W, 3, width of floor fields; must satisfy 2^FLOOR_W >= NUM_FLOORS
- TRAVEL_TICKS, 4, ticks to move one floor (>=1)
- DOOR_TICKS, 3, ticks the door stays open (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- tick  in  1  one-cycle timing strobe; counters advance only when tick=1
- call_valid  in  1  call strobe, sampled every clk edge
- call_floor  in  FLOOR_W  floor of the call
- call_type  in  2  0=inside, 1=hall up, 2=hall down, 3=ignored
- floor  out  FLOOR_W  current floor
- dir  out  1  1=up, 0=down
- moving  out  1  high in MOVE
- door_open  out  1  high in DOOR
- arrived  out  1  one-cycle pulse on entering DOOR
- req_in  out  NUM_FLOORS  pending inside calls
- req_up  out  NUM_FLOORS  pending hall-up calls
- req_down  out  NUM_FLOORS  pending hall-down calls

Behaviour:
- Reset (reset=0 at clk edge, any state, including mid-travel): state=IDLE, floor=0, dir=1, moving=0, door_open=0, arrived=0, all request vectors 0, counters 0.
- Call latching (cycle after call_valid=1): set the bit selected by call_type and call_floor.
- A call is ignored, with no state change, when any of the following holds:
  - call_floor >= NUM_FLOORS
  - call_type=3
  - up call at the top floor
  - down call at floor 0
- Same-floor call while in IDLE or DOOR: the bit is not latched. Instead the door (re)opens: state=DOOR, door counter=DOOR_TICKS. No arrived pulse.
- State machine:
  - IDLE: when no request is pending, stay.
  - Otherwise choose a direction:
    - Keep dir if any request exists strictly ahead in dir.
    - Else flip dir.
  - Then enter MOVE with travel counter=TRAVEL_TICKS, same cycle as the evaluation.
  - Flipping dir never changes floor.
- MOVE:
  - On tick, decrement the travel counter.
  - On the tick where it reaches 0, floor ±1 per dir, then evaluate stop at the new floor in the same cycle.
  - Stop if any of:
    - req_in[f]
    - dir=1 and req_up[f]
    - dir=0 and req_down[f]
    - no request strictly beyond f in dir
  - Stop action:
    - Clear req_in[f] and the hall bit matching dir.
    - If no requests remain beyond f in dir, also clear the opposite hall bit.
    - Enter DOOR with door counter=DOOR_TICKS; arrived=1 for that one cycle.
  - No stop: reload the travel counter to TRAVEL_TICKS and stay in MOVE.
  - Floor never leaves 0..NUM_FLOORS-1. Direction evaluation guarantees this; there is no wrap-around.
- DOOR:
  - On tick, decrement the door counter.
  - On reaching 0, go to IDLE. IDLE re-evaluates on the following cycle.
- Simultaneous set and clear of the same request bit in one cycle: the clear wins, because the call is served by the door opening.
- Outputs are registered. moving and door_open are decoded from the registered state.
- Latency: a call from idle at floor 0 to floor k produces door_open after k*TRAVEL_TICKS ticks plus 1 clk.

Test Plan:
- Reset mid-MOVE at floor 3 with req_in=8'h80 -> next cycle floor=0, dir=1, moving=0, req_in=0.
- From reset, inside call to floor 5, TRAVEL_TICKS=4, tick every cycle -> floor reaches 5 after 20 ticks; arrived pulses once; door_open held for 3 ticks; req_in=0; back to IDLE.
- At floor 2 moving up with req_in[6] set, hall down at floor 4 and hall up at floor 5 issued -> stops at 5 (up call), then 6; reverses; stops at 4 and clears req_down[4]. Floor 4 is not stopped on during the upward pass.
- Up call at top floor, down call at floor 0, call_floor=NUM_FLOORS, call_type=3 -> all request vectors remain 0; state stays IDLE.
- In DOOR at floor 3 with door counter=1, call inside floor 3 -> counter reloads to DOOR_TICKS; no bit latched; no arrived pulse.
- Call for floor f arriving in the same cycle as the stop at f -> bit cleared; door_open=1; no second stop.

Source files
------------

// File: rtl/elevator_core_n.sv
// Parametrised elevator core: latches inside/hall calls, serves them with a SCAN policy,
// and models travel and door dwell time with tick-driven counters.
module elevator_core_n #(
    parameter int unsigned NUM_FLOORS   = 8,
    parameter int unsigned FLOOR_W      = 3,
    parameter int unsigned TRAVEL_TICKS = 4,
    parameter int unsigned DOOR_TICKS   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  call_valid,
    input  logic [FLOOR_W-1:0]    call_floor,
    input  logic [1:0]            call_type,
    output logic [FLOOR_W-1:0]    floor,
    output logic                  dir,
    output logic                  moving,
    output logic                  door_open,
    output logic                  arrived,
    output logic [NUM_FLOORS-1:0] req_in,
    output logic [NUM_FLOORS-1:0] req_up,
    output logic [NUM_FLOORS-1:0] req_down
);

    localparam int unsigned MaxTicks = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
    localparam int unsigned CntW     = $clog2(MaxTicks + 1);

    typedef logic [NUM_FLOORS-1:0] vec_t;
    typedef enum logic [1:0] {StIdle, StMove, StDoor} state_e;

    state_e             state_q, state_d;
    logic [FLOOR_W-1:0] floor_q, floor_d;
    logic               dir_q, dir_d;
    logic               arrived_q, arrived_d;
    logic [CntW-1:0]    travel_q, travel_d;
    logic [CntW-1:0]    door_q, door_d;
    vec_t               req_in_q, req_in_d;
    vec_t               req_up_q, req_up_d;
    vec_t               req_down_q, req_down_d;

    logic               call_ok, call_here;
    vec_t               call_oh, here_oh, next_oh, pending;
    vec_t               set_in, set_up, set_down;
    vec_t               clr_in, clr_up, clr_down;
    logic [FLOOR_W-1:0] next_floor;
    logic               ahead_here, ahead_next, stop;

    function automatic vec_t onehot(input logic [FLOOR_W-1:0] f);
        return vec_t'(1) << f;
    endfunction

    // Mask of floors strictly beyond f in the given direction (up=1).
    function automatic vec_t beyond(input logic [FLOOR_W-1:0] f, input logic up);
        vec_t oh;
        oh = onehot(f);
        return up ? ~((oh << 1) - vec_t'(1)) : (oh - vec_t'(1));
    endfunction

    // Call qualification and the lookahead terms used by the scheduler.
    always_comb begin
        call_ok = call_valid
                  && (32'(call_floor) < NUM_FLOORS)
                  && (call_type != 2'd3)
                  && !((call_type == 2'd1) && (32'(call_floor) == NUM_FLOORS - 1))
                  && !((call_type == 2'd2) && (call_floor == '0));
        // A call at the current floor while stationary just reopens the door.
        call_here  = call_ok && (call_floor == floor_q) && (state_q != StMove);
        call_oh    = onehot(call_floor);
        here_oh    = onehot(floor_q);
        pending    = req_in_q | req_up_q | req_down_q;
        ahead_here = |(pending & beyond(floor_q, dir_q));
        next_floor = dir_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
        next_oh    = onehot(next_floor);
        ahead_next = |(pending & beyond(next_floor, dir_q));
        stop       = (|(req_in_q & next_oh))
                     || (dir_q && (|(req_up_q & next_oh)))
                     || (!dir_q && (|(req_down_q & next_oh)))
                     || !ahead_next;
        set_in   = '0;
        set_up   = '0;
        set_down = '0;
        if (call_ok && !call_here) begin
            unique case (call_type)
                2'd0:    set_in   = call_oh;
                2'd1:    set_up   = call_oh;
                2'd2:    set_down = call_oh;
                default: ;
            endcase
        end
    end

    // SCAN state machine; request clears override same-cycle sets.
    always_comb begin
        state_d   = state_q;
        floor_d   = floor_q;
        dir_d     = dir_q;
        travel_d  = travel_q;
        door_d    = door_q;
        arrived_d = 1'b0;
        clr_in    = '0;
        clr_up    = '0;
        clr_down  = '0;
        unique case (state_q)
            StIdle: begin
                if (call_here) begin
                    state_d = StDoor;
                    door_d  = CntW'(DOOR_TICKS);
                end else if (|(pending & here_oh)) begin
                    // Defensive: serve anything left at this floor instead of moving off-range.
                    clr_in   = here_oh;
                    clr_up   = here_oh;
                    clr_down = here_oh;
                    state_d  = StDoor;
                    door_d   = CntW'(DOOR_TICKS);
                end else if (|pending) begin
                    if (!ahead_here) begin
                        dir_d = ~dir_q;
                    end
                    state_d  = StMove;
                    travel_d = CntW'(TRAVEL_TICKS);
                end
            end
            StMove: begin
                if (tick) begin
                    if (travel_q == CntW'(1)) begin
                        floor_d = next_floor;
                        if (stop) begin
                            clr_in = next_oh;
                            if (dir_q || !ahead_next) clr_up = next_oh;
                            if (!dir_q || !ahead_next) clr_down = next_oh;
                            state_d   = StDoor;
                            door_d    = CntW'(DOOR_TICKS);
                            travel_d  = '0;
                            arrived_d = 1'b1;
                        end else begin
                            travel_d = CntW'(TRAVEL_TICKS);
                        end
                    end else begin
                        travel_d = travel_q - CntW'(1);
                    end
                end
            end
            StDoor: begin
                if (call_here) begin
                    door_d = CntW'(DOOR_TICKS);
                end else if (tick) begin
                    door_d = door_q - CntW'(1);
                    if (door_q == CntW'(1)) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        req_in_d   = (req_in_q | set_in) & ~clr_in;
        req_up_d   = (req_up_q | set_up) & ~clr_up;
        req_down_d = (req_down_q | set_down) & ~clr_down;
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            floor_q    <= '0;
            dir_q      <= 1'b1;
            arrived_q  <= 1'b0;
            travel_q   <= '0;
            door_q     <= '0;
            req_in_q   <= '0;
            req_up_q   <= '0;
            req_down_q <= '0;
        end else begin
            state_q    <= state_d;
            floor_q    <= floor_d;
            dir_q      <= dir_d;
            arrived_q  <= arrived_d;
            travel_q   <= travel_d;
            door_q     <= door_d;
            req_in_q   <= req_in_d;
            req_up_q   <= req_up_d;
            req_down_q <= req_down_d;
        end
    end

    assign floor     = floor_q;
    assign dir       = dir_q;
    assign moving    = (state_q == StMove);
    assign door_open = (state_q == StDoor);
    assign arrived   = arrived_q;
    assign req_in    = req_in_q;
    assign req_up    = req_up_q;
    assign req_down  = req_down_q;

endmodule
